move_controller: RTL and testbench
==================================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL provide parameter FIRST_PLAYER, default 2'd1, cell code of the player who moves first after reset/new game (legal values 1 or 2).
REQ-002 SHALL provide port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL provide port new_game  in  1  synchronous clear of board and game state.
REQ-005 SHALL provide port move_valid  in  1  move request qualifier.
REQ-006 SHALL provide port move_ready  out  1  controller can accept a move.
REQ-007 SHALL provide port move_row  in  3  target row, legal 0..4.
REQ-008 SHALL provide port move_col  in  3  target column, legal 0..4.
REQ-009 SHALL provide ports board1..board25  out  2 each  cell state, index = row*5+col+1; 0 empty, 1 player X, 2 player O, 3 never driven.
REQ-010 SHALL provide port cur_player  out  2  code of player to move (1 or 2).
REQ-011 SHALL provide port move_ack  out  1  one-cycle pulse, move committed.
REQ-012 SHALL provide port move_err  out  1  one-cycle pulse, move rejected.
REQ-013 SHALL provide port err_code  out  2  00 none, 01 out of range, 10 cell occupied; valid while move_err=1, else 00.
REQ-014 SHALL provide port move_count  out  5  committed moves this game, 0..25.
REQ-015 SHALL provide port game_over  in  1  downstream win/full indication (board_full is_full OR win detector).
REQ-016 SHALL provide port locked  out  1  game finished, moves refused.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, RESP, LOCKED.
REQ-018 IDLE SHALL drive move_ready=1; all other states move_ready=0.
REQ-019 A move SHALL be accepted on a rising edge where move_valid=1 and move_ready=1; row/col latched; IDLE->CHECK.
REQ-020 CHECK SHALL evaluate: row>4 or col>4 -> error 01; else target cell nonzero -> error 10; else legal; out-of-range check takes priority.
REQ-021 On CHECK->RESP edge of a legal move, the target cell SHALL be written with cur_player, cur_player SHALL toggle 1<->2, move_count SHALL increment.
REQ-022 RESP SHALL last exactly one cycle with move_ack=1 (legal) or move_err=1 plus err_code (illegal); board, player and count unchanged by illegal moves.
REQ-023 Accept-to-response latency SHALL be 2 cycles: accept edge T, pulse visible in cycle T+2, board update visible from T+2.
REQ-024 RESP->LOCKED if move_count=25 or game_over=1; else RESP->IDLE.
REQ-025 IDLE->LOCKED when game_over=1, taking priority over a simultaneous move_valid (move not accepted).
REQ-026 LOCKED SHALL drive locked=1 and hold until reset or new_game; move_valid ignored.
REQ-027 new_game=1 SHALL, on the next edge from any state: clear all cells to 0, cur_player=FIRST_PLAYER, move_count=0, drop any in-flight move without ack/err, enter IDLE.
REQ-028 new_game SHALL take priority over move_valid and game_over in the same cycle.
REQ-029 move_count SHALL never exceed 25; no wrap.
REQ-030 Cells SHALL only ever hold 0, 1 or 2.

Reset
REQ-031 reset=1 SHALL, on the rising edge, force IDLE, all board cells 0, cur_player=FIRST_PLAYER, move_count=0, move_ack=0, move_err=0, err_code=00, locked=0.
REQ-032 reset SHALL take priority over new_game and all other inputs, including mid-move (CHECK/RESP): pending move discarded, no pulse issued.
REQ-033 After reset deasserts, move_ready SHALL be 1 in the first cycle.

Verification
REQ-034 Legal move: after reset, move (2,3) -> cycle T+2 move_ack=1, board14=1, cur_player=2, move_count=1.
REQ-035 Occupied: repeat move (2,3) -> move_err=1, err_code=10, board14 stays 1, cur_player stays 2, move_count stays 1.
REQ-036 Out of range: move (5,0) -> move_err=1, err_code=01, no cell changes; move (7,7) same result.
REQ-037 Fill: 25 legal moves alternating players -> move_count=25, locked=1, cells alternate 1/2 by move order, 26th move_valid gets no response, move_ready=0.
REQ-038 game_over: pulse game_over=1 in IDLE with move_valid=1 same cycle -> move not accepted, locked=1; then new_game -> all cells 0, move_count=0, locked=0, move_ready=1.
REQ-039 Reset mid-move: accept move, assert reset in CHECK cycle -> no move_ack/move_err, target cell 0, move_count=0.

Source files
------------

// File: rtl/move_controller.sv
// Move controller for a 5x5 board game. It accepts a move, checks range and
// occupancy, commits legal moves, and pulses move_ack or move_err.
module move_controller #(
    parameter logic [1:0] FIRST_PLAYER = 2'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [2:0] move_row,
    input  logic [2:0] move_col,
    output logic [1:0] board1,
    output logic [1:0] board2,
    output logic [1:0] board3,
    output logic [1:0] board4,
    output logic [1:0] board5,
    output logic [1:0] board6,
    output logic [1:0] board7,
    output logic [1:0] board8,
    output logic [1:0] board9,
    output logic [1:0] board10,
    output logic [1:0] board11,
    output logic [1:0] board12,
    output logic [1:0] board13,
    output logic [1:0] board14,
    output logic [1:0] board15,
    output logic [1:0] board16,
    output logic [1:0] board17,
    output logic [1:0] board18,
    output logic [1:0] board19,
    output logic [1:0] board20,
    output logic [1:0] board21,
    output logic [1:0] board22,
    output logic [1:0] board23,
    output logic [1:0] board24,
    output logic [1:0] board25,
    output logic [1:0] cur_player,
    output logic       move_ack,
    output logic       move_err,
    output logic [1:0] err_code,
    output logic [4:0] move_count,
    input  logic       game_over,
    output logic       locked
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP, LOCKED} state_t;

    state_t     state_q;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [1:0] cells_q [25];
    logic [1:0] player_q;
    logic [4:0] count_q;
    logic       ack_q;
    logic       err_q;
    logic [1:0] code_q;

    logic [4:0] idx_d;
    logic       range_err_d;
    logic       occupied_d;

    // For out-of-range coordinates idx_d may alias a real cell; range_err_d wins.
    always_comb begin
        range_err_d = (row_q > 3'd4) || (col_q > 3'd4);
        idx_d       = 5'(row_q) * 5'd5 + 5'(col_q);
        occupied_d  = 1'b0;
        for (int unsigned i = 0; i < 25; i++) begin
            if (idx_d == 5'(i) && cells_q[i] != 2'd0) occupied_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        ack_q  <= 1'b0;
        err_q  <= 1'b0;
        code_q <= 2'b00;
        if (reset || new_game) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            player_q <= FIRST_PLAYER;
            count_q  <= '0;
            for (int unsigned i = 0; i < 25; i++) cells_q[i] <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (game_over) begin
                        state_q <= LOCKED;
                    end else if (move_valid) begin
                        row_q   <= move_row;
                        col_q   <= move_col;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q <= RESP;
                    if (range_err_d) begin
                        err_q  <= 1'b1;
                        code_q <= 2'b01;
                    end else if (occupied_d) begin
                        err_q  <= 1'b1;
                        code_q <= 2'b10;
                    end else begin
                        ack_q    <= 1'b1;
                        player_q <= player_q ^ 2'b11;
                        count_q  <= count_q + 5'd1;
                        for (int unsigned i = 0; i < 25; i++) begin
                            if (idx_d == 5'(i)) cells_q[i] <= player_q;
                        end
                    end
                end
                RESP: begin
                    if (count_q == 5'd25 || game_over) state_q <= LOCKED;
                    else                               state_q <= IDLE;
                end
                default: state_q <= LOCKED;
            endcase
        end
    end

    assign move_ready = (state_q == IDLE);
    assign locked     = (state_q == LOCKED);
    assign cur_player = player_q;
    assign move_count = count_q;
    assign move_ack   = ack_q;
    assign move_err   = err_q;
    assign err_code   = code_q;

    assign board1  = cells_q[0];
    assign board2  = cells_q[1];
    assign board3  = cells_q[2];
    assign board4  = cells_q[3];
    assign board5  = cells_q[4];
    assign board6  = cells_q[5];
    assign board7  = cells_q[6];
    assign board8  = cells_q[7];
    assign board9  = cells_q[8];
    assign board10 = cells_q[9];
    assign board11 = cells_q[10];
    assign board12 = cells_q[11];
    assign board13 = cells_q[12];
    assign board14 = cells_q[13];
    assign board15 = cells_q[14];
    assign board16 = cells_q[15];
    assign board17 = cells_q[16];
    assign board18 = cells_q[17];
    assign board19 = cells_q[18];
    assign board20 = cells_q[19];
    assign board21 = cells_q[20];
    assign board22 = cells_q[21];
    assign board23 = cells_q[22];
    assign board24 = cells_q[23];
    assign board25 = cells_q[24];

endmodule

// File: tb/tb_move_controller.sv
// Scoreboard bench for move_controller: stimulus pushes expected responses,
// a negedge monitor pops and compares them against move_ack/move_err pulses.
module tb_move_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic       move_valid = 1'b0;
    logic       move_ready;
    logic [2:0] move_row = '0;
    logic [2:0] move_col = '0;
    logic [1:0] b [25];
    logic [1:0] cur_player;
    logic       move_ack;
    logic       move_err;
    logic [1:0] err_code;
    logic [4:0] move_count;
    logic       game_over = 1'b0;
    logic       locked;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned cyc    = 0;

    typedef struct {
        logic        err;
        logic [1:0]  code;
        int unsigned cyc;
    } exp_t;
    exp_t exp_q [$];

    move_controller #(.FIRST_PLAYER(2'd1)) dut (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid(move_valid), .move_ready(move_ready),
        .move_row(move_row), .move_col(move_col),
        .board1(b[0]),   .board2(b[1]),   .board3(b[2]),   .board4(b[3]),   .board5(b[4]),
        .board6(b[5]),   .board7(b[6]),   .board8(b[7]),   .board9(b[8]),   .board10(b[9]),
        .board11(b[10]), .board12(b[11]), .board13(b[12]), .board14(b[13]), .board15(b[14]),
        .board16(b[15]), .board17(b[16]), .board18(b[17]), .board19(b[18]), .board20(b[19]),
        .board21(b[20]), .board22(b[21]), .board23(b[22]), .board24(b[23]), .board25(b[24]),
        .cur_player(cur_player), .move_ack(move_ack), .move_err(move_err),
        .err_code(err_code), .move_count(move_count),
        .game_over(game_over), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse must match the oldest expected response, on time.
    always @(negedge clk) begin
        if (move_ack || move_err) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: ack=%0b err=%0b code=%0d at cyc %0d, required no pulse",
                         move_ack, move_err, err_code, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (move_err == e.err && move_ack == !e.err && err_code == e.code && cyc == e.cyc)
                    passed++;
                else
                    $display("FAIL response: ack=%0b err=%0b code=%0d cyc=%0d, required ack=%0b err=%0b code=%0d cyc=%0d",
                             move_ack, move_err, err_code, cyc, !e.err, e.err, e.code, e.cyc);
            end
        end else if (err_code != 2'b00) begin
            total++;
            $display("FAIL err_code_idle: got %0d, required 0", err_code);
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one move, queues its expected response, returns back in IDLE.
    task automatic do_move(input logic [2:0] r, input logic [2:0] c,
                           input logic is_err, input logic [1:0] code);
        int unsigned n = 0;
        exp_t e;
        while (!move_ready && n < 20) begin
            tick();
            n++;
        end
        if (!move_ready) begin
            total++;
            $display("FAIL ready_timeout: move_ready=0 after %0d cycles, required 1", n);
        end else begin
            move_valid = 1'b1;
            move_row   = r;
            move_col   = c;
            tick();
            move_valid = 1'b0;
            // cyc counts edges: the pulse is sampled after the edge following acceptance.
            e.err  = is_err;
            e.code = code;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
            tick();
            tick();
        end
    endtask

    task automatic chk_board_clear(input string name);
        int unsigned nz = 0;
        for (int i = 0; i < 25; i++) if (b[i] != 2'd0) nz++;
        chk(name, nz, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", move_ready, 1);
        chk("rst_count", move_count, 0);
        chk("rst_player", cur_player, 1);
        chk("rst_locked", locked, 0);
        chk("rst_ack_err", {move_ack, move_err}, 0);
        chk_board_clear("rst_board");

        do_move(3'd2, 3'd3, 1'b0, 2'b00);
        chk("legal_b14", b[13], 1);
        chk("legal_player", cur_player, 2);
        chk("legal_count", move_count, 1);

        do_move(3'd2, 3'd3, 1'b1, 2'b10);
        chk("occ_b14", b[13], 1);
        chk("occ_player", cur_player, 2);
        chk("occ_count", move_count, 1);

        do_move(3'd5, 3'd0, 1'b1, 2'b01);
        do_move(3'd7, 3'd7, 1'b1, 2'b01);
        do_move(3'd0, 3'd5, 1'b1, 2'b01);
        chk("oor_count", move_count, 1);
        chk("oor_player", cur_player, 2);
        chk("oor_b1", b[0], 0);

        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk_board_clear("ng_board");
        chk("ng_player", cur_player, 1);
        chk("ng_count", move_count, 0);

        for (int i = 0; i < 25; i++) do_move(3'(i / 5), 3'(i % 5), 1'b0, 2'b00);
        chk("fill_count", move_count, 25);
        chk("fill_locked", locked, 1);
        chk("fill_ready", move_ready, 0);
        for (int i = 0; i < 25; i++) chk($sformatf("fill_b%0d", i + 1), b[i], (i % 2 == 0) ? 1 : 2);
        move_valid = 1'b1;
        move_row   = 3'd0;
        move_col   = 3'd0;
        for (int i = 0; i < 4; i++) tick();
        move_valid = 1'b0;
        chk("move26_count", move_count, 25);
        chk("move26_locked", locked, 1);

        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ng2_locked", locked, 0);
        do_move(3'd1, 3'd1, 1'b0, 2'b00);
        chk("pre_go_b7", b[6], 1);

        game_over  = 1'b1;
        move_valid = 1'b1;
        move_row   = 3'd0;
        move_col   = 3'd0;
        tick();
        game_over  = 1'b0;
        move_valid = 1'b0;
        tick();
        tick();
        chk("go_locked", locked, 1);
        chk("go_ready", move_ready, 0);
        chk("go_b1", b[0], 0);
        chk("go_count", move_count, 1);

        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk_board_clear("go_ng_board");
        chk("go_ng_count", move_count, 0);
        chk("go_ng_locked", locked, 0);
        chk("go_ng_ready", move_ready, 1);

        move_valid = 1'b1;
        move_row   = 3'd4;
        move_col   = 3'd4;
        tick();
        move_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ready", move_ready, 1);
        tick();
        tick();
        chk("midrst_b25", b[24], 0);
        chk("midrst_count", move_count, 0);

        move_valid = 1'b1;
        move_row   = 3'd0;
        move_col   = 3'd2;
        tick();
        move_valid = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        tick();
        chk("midng_b3", b[2], 0);
        chk("midng_count", move_count, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
